l1_line_cache: RTL and testbench

- Direct-mapped, write-back, write-allocate cache between the CPU data path and the 2-cycle line memory.
- CPU side: 16-bit word accesses.
- Memory side: 64-bit (4-word) line reads and writes using the memory's delayed read_ack/write_ack handshake.
- Hits complete in the request cycle. Misses stall the CPU while a dirty victim is written back and the new line is filled.

---
 rtl/l1_line_cache.sv | 161 ++++++++++++++++
 tb/tb_l1_line_cache.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_line_cache.sv
// l1_line_cache: direct-mapped, write-back, write-allocate cache between a 16-bit CPU word port
// and a 4-word line memory with a delayed read_ack/write_ack handshake.
//
// Ports:
//   clk, reset_n                - clock, asynchronous active-low reset
//   cpu_read/cpu_write          - word request, held until cpu_ready (both set = write)
//   cpu_address, cpu_wdata      - word address and write data
//   cpu_rdata, cpu_ready        - read data / completion, combinational on an IDLE hit
//   mem_read/mem_write          - line fill / writeback requests (never together)
//   mem_address                 - line address, low two bits always 00
//   mem_wdata, mem_rdata        - writeback and fill lines, word 0 in the top WORD_SIZE bits
//   mem_read_ack, mem_write_ack - memory acknowledges (low while busy, high when done)
//
// Optional feature (macro CACHE_STATS_EN): adds saturating 16-bit hit_count / miss_count outputs.
module l1_line_cache #(
  parameter int WORD_SIZE  = 16,
  parameter int INDEX_BITS = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cpu_read,
  input  logic                   cpu_write,
  input  logic [WORD_SIZE-1:0]   cpu_address,
  input  logic [WORD_SIZE-1:0]   cpu_wdata,
  output logic [WORD_SIZE-1:0]   cpu_rdata,
  output logic                   cpu_ready,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [WORD_SIZE-1:0]   mem_address,
  output logic [4*WORD_SIZE-1:0] mem_wdata,
  input  logic [4*WORD_SIZE-1:0] mem_rdata,
  input  logic                   mem_read_ack,
  input  logic                   mem_write_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count
`endif
);

  localparam int Lines   = 1 << INDEX_BITS;
  localparam int TagBits = WORD_SIZE - INDEX_BITS - 2;
  localparam int LineW   = 4 * WORD_SIZE;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StWbReq    = 3'd1;
  localparam logic [2:0] StWbWait   = 3'd2;
  localparam logic [2:0] StFillReq  = 3'd3;
  localparam logic [2:0] StFillWait = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [Lines-1:0]     valid_q, dirty_q;
  logic [TagBits-1:0]   tag_q  [Lines];
  logic [WORD_SIZE-1:0] data_q [Lines][4];
  // Line address of the miss being serviced, latched so the memory side stays stable
  // even if the CPU drops or changes its request mid-miss.
  logic [WORD_SIZE-3:0] miss_line_q;

  logic [INDEX_BITS-1:0] cur_idx, miss_idx;
  logic [TagBits-1:0]    cur_tag, miss_tag;
  logic [1:0]            cur_off;
  logic                  req, hit, miss, wb_done, fill_done;

  assign cur_off   = cpu_address[1:0];
  assign cur_idx   = cpu_address[INDEX_BITS+1:2];
  assign cur_tag   = cpu_address[WORD_SIZE-1:INDEX_BITS+2];
  assign miss_idx  = miss_line_q[INDEX_BITS-1:0];
  assign miss_tag  = miss_line_q[WORD_SIZE-3:INDEX_BITS];

  assign req       = cpu_read | cpu_write;
  assign hit       = (state_q == StIdle) && req && valid_q[cur_idx] && (tag_q[cur_idx] == cur_tag);
  assign miss      = (state_q == StIdle) && req && !hit;
  assign wb_done   = (state_q == StWbWait) && mem_write_ack;
  assign fill_done = (state_q == StFillWait) && mem_read_ack;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (miss) begin
          state_d = (valid_q[cur_idx] && dirty_q[cur_idx]) ? StWbReq : StFillReq;
        end
      end
      // Wait for ack to drop first so a stale high ack is never taken as completion.
      StWbReq:    if (!mem_write_ack) state_d = StWbWait;
      StWbWait:   if (mem_write_ack)  state_d = StFillReq;
      StFillReq:  if (!mem_read_ack)  state_d = StFillWait;
      StFillWait: if (mem_read_ack)   state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      dirty_q     <= '0;
      miss_line_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss) miss_line_q <= cpu_address[WORD_SIZE-1:2];
      if (hit && cpu_write) dirty_q[cur_idx] <= 1'b1;
      if (wb_done) dirty_q[miss_idx] <= 1'b0;
      if (fill_done) begin
        valid_q[miss_idx] <= 1'b1;
        dirty_q[miss_idx] <= 1'b0;
      end
    end
  end

  // Tag and data arrays need no reset: they are only meaningful behind valid_q.
  always_ff @(posedge clk) begin
    if (hit && cpu_write) data_q[cur_idx][cur_off] <= cpu_wdata;
    if (fill_done) begin
      tag_q[miss_idx] <= miss_tag;
      for (int k = 0; k < 4; k++) begin
        data_q[miss_idx][k] <= mem_rdata[LineW-1-k*WORD_SIZE -: WORD_SIZE];
      end
    end
  end

  always_comb begin
    cpu_ready   = hit;
    cpu_rdata   = (hit && !cpu_write) ? data_q[cur_idx][cur_off] : '0;
    mem_read    = (state_q == StFillReq) || (state_q == StFillWait);
    mem_write   = (state_q == StWbReq) || (state_q == StWbWait);
    mem_address = '0;
    mem_wdata   = '0;
    if (mem_write) begin
      mem_address = {tag_q[miss_idx], miss_idx, 2'b00};
      for (int k = 0; k < 4; k++) begin
        mem_wdata[LineW-1-k*WORD_SIZE -: WORD_SIZE] = data_q[miss_idx][k];
      end
    end else if (mem_read) begin
      mem_address = {miss_tag, miss_idx, 2'b00};
    end
  end

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;
  // Set for the single IDLE cycle after a fill, where the retried request is not a first-lookup hit.
  logic        retry_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      retry_q    <= 1'b0;
    end else begin
      if (hit && !retry_q && (hit_cnt_q != 16'hFFFF)) hit_cnt_q <= hit_cnt_q + 16'd1;
      if (miss && (miss_cnt_q != 16'hFFFF)) miss_cnt_q <= miss_cnt_q + 16'd1;
      if (fill_done) retry_q <= 1'b1;
      else if (state_q == StIdle) retry_q <= 1'b0;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_l1_line_cache.sv
// Self-checking bench for l1_line_cache: directed vector table from the reference sequence,
// reset-mid-miss and dropped-request sequences, then randomized accesses against a
// word-level memory image plus per-index residency model.
module tb_l1_line_cache;

  logic        clk;
  logic        reset_n;
  logic        cpu_read, cpu_write;
  logic [15:0] cpu_address, cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        mem_read, mem_write;
  logic [15:0] mem_address;
  logic [63:0] mem_wdata, mem_rdata;
  logic        mem_read_ack, mem_write_ack;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  l1_line_cache dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cpu_read     (cpu_read),
    .cpu_write    (cpu_write),
    .cpu_address  (cpu_address),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_ready    (cpu_ready),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_read_ack (mem_read_ack),
    .mem_write_ack(mem_write_ack)
`ifdef CACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] init_word(input int i);
    case (i)
      0:       return 16'h9023;
      1:       return 16'h0001;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      'h43:    return 16'h6000;
      default: return 16'(i * 16'h0137 + 16'h5A5A);
    endcase
  endfunction

  // CPU-visible memory image: what every word should read as, regardless of caching.
  logic [15:0] ref_mem [0:255];
  // Residency model per index.
  bit          rv [4];
  bit          rdty [4];
  logic [11:0] rt [4];

  // ---------------- two-cycle line memory model ----------------
  logic [15:0] mem [0:255];
  bit          loaded = 1'b0;
  int          rd_cnt, wr_cnt;
  int          rd_count = 0, wr_count = 0;
  logic [15:0] last_rd_addr = '0, last_wr_addr = '0;
  logic [63:0] last_wr_data = '0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_read_ack  <= 1'b1;
      mem_write_ack <= 1'b1;
      rd_cnt        <= 0;
      wr_cnt        <= 0;
      if (!loaded) begin
        for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        loaded <= 1'b1;
      end
    end else begin
      if (mem_read) begin
        case (rd_cnt)
          0: begin mem_read_ack <= 1'b0; rd_cnt <= 1; end
          1: rd_cnt <= 2;
          2: begin
            mem_read_ack <= 1'b1;
            mem_rdata    <= {mem[mem_address[7:0]], mem[mem_address[7:0]+1],
                             mem[mem_address[7:0]+2], mem[mem_address[7:0]+3]};
            rd_count     <= rd_count + 1;
            last_rd_addr <= mem_address;
            check("fill_addr_align", {62'd0, mem_address[1:0]}, 64'd0);
            rd_cnt       <= 3;
          end
          default: ;
        endcase
      end else begin
        rd_cnt <= 0;
      end
      if (mem_write) begin
        case (wr_cnt)
          0: begin mem_write_ack <= 1'b0; wr_cnt <= 1; end
          1: wr_cnt <= 2;
          2: begin
            mem_write_ack <= 1'b1;
            for (int k = 0; k < 4; k++) begin
              mem[mem_address[7:0]+k] <= mem_wdata[63-16*k -: 16];
            end
            check("wb_line", mem_wdata,
                  {ref_mem[mem_address[7:0]], ref_mem[mem_address[7:0]+1],
                   ref_mem[mem_address[7:0]+2], ref_mem[mem_address[7:0]+3]});
            wr_count     <= wr_count + 1;
            last_wr_addr <= mem_address;
            last_wr_data <= mem_wdata;
            wr_cnt       <= 3;
          end
          default: ;
        endcase
      end else begin
        wr_cnt <= 0;
      end
    end
  end

  // ---------------- memory-side protocol monitor ----------------
  logic        prev_r = 1'b0, prev_w = 1'b0;
  logic [15:0] prev_raddr, prev_waddr;
  logic [63:0] prev_wdata;

  always @(negedge clk) begin
    if (reset_n) begin
      check("rd_wr_exclusive", {62'd0, mem_read, mem_write} == 64'd3 ? 64'd1 : 64'd0, 64'd0);
      if (prev_r && mem_read) check("rd_addr_stable", mem_address, prev_raddr);
      if (prev_w && mem_write) check("wb_stable", {mem_address, mem_wdata[47:0]},
                                     {prev_waddr, prev_wdata[47:0]});
      prev_r     <= mem_read;
      prev_w     <= mem_write;
      prev_raddr <= mem_address;
      prev_waddr <= mem_address;
      prev_wdata <= mem_wdata;
    end else begin
      prev_r <= 1'b0;
      prev_w <= 1'b0;
    end
  end

  // ---------------- CPU access helpers ----------------
  task automatic access(input bit wr, input bit both, input logic [15:0] a, input logic [15:0] d,
                        output bit hit, output logic [15:0] rd, output bit ok);
    int cyc = 0;
    cpu_address = a;
    cpu_wdata   = d;
    cpu_write   = wr;
    cpu_read    = !wr || both;
    ok          = 1'b0;
    while (cyc < 60) begin
      @(negedge clk);
      if (cpu_ready) begin
        ok = 1'b1;
        break;
      end
      cyc++;
    end
    hit = (cyc == 0);
    rd  = cpu_rdata;
    @(posedge clk);
    #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic run_checked(input string nm, input bit wr, input bit both,
                             input logic [15:0] a, input logic [15:0] d,
                             output bit hit, output logic [15:0] rd);
    int          idx = int'(a[3:2]);
    bit          exp_hit = rv[idx] && (rt[idx] == a[15:4]);
    bit          exp_wb  = !exp_hit && rv[idx] && rdty[idx];
    int          rc0 = rd_count, wc0 = wr_count;
    bit          ok;
    access(wr, both, a, d, hit, rd, ok);
    check({nm, " completes"}, {63'd0, ok}, 64'd1);
    if (ok) begin
      check({nm, " hit"}, {63'd0, hit}, {63'd0, exp_hit});
      if (!wr) check({nm, " rdata"}, rd, ref_mem[a[7:0]]);
      check({nm, " fills"}, rd_count - rc0, exp_hit ? 0 : 1);
      check({nm, " writebacks"}, wr_count - wc0, exp_wb ? 1 : 0);
    end
    if (!exp_hit) begin
      rv[idx]   = 1'b1;
      rt[idx]   = a[15:4];
      rdty[idx] = 1'b0;
    end
    if (wr) begin
      rdty[idx]       = 1'b1;
      ref_mem[a[7:0]] = d;
    end
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          exp_hit;
    logic [15:0] exp_rdata;
  } vec_t;

  initial begin
    vec_t        vecs [5];
    bit          hit;
    logic [15:0] rd;
    int          cyc;

    vecs[0] = '{wr: 0, addr: 16'h0001, wdata: 16'h0, exp_hit: 0, exp_rdata: 16'h0001};
    vecs[1] = '{wr: 0, addr: 16'h0002, wdata: 16'h0, exp_hit: 1, exp_rdata: 16'hFFFF};
    vecs[2] = '{wr: 1, addr: 16'h0003, wdata: 16'h1234, exp_hit: 1, exp_rdata: 16'h0};
    vecs[3] = '{wr: 0, addr: 16'h0003, wdata: 16'h0, exp_hit: 1, exp_rdata: 16'h1234};
    vecs[4] = '{wr: 0, addr: 16'h0043, wdata: 16'h0, exp_hit: 0, exp_rdata: 16'h6000};

    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    for (int i = 0; i < 4; i++) begin rv[i] = 0; rdty[i] = 0; rt[i] = '0; end

    reset_n = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = '0; cpu_wdata = '0;
    #1;
    check("reset outputs", {cpu_ready, mem_read, mem_write, cpu_rdata, mem_address},
          {3'b000, 16'h0, 16'h0});
    check("reset wdata", mem_wdata, 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed sequence.
    for (int i = 0; i < 5; i++) begin
      run_checked($sformatf("vec%0d", i), vecs[i].wr, 1'b0, vecs[i].addr, vecs[i].wdata, hit, rd);
      check($sformatf("vec%0d tbl_hit", i), {63'd0, hit}, {63'd0, vecs[i].exp_hit});
      if (!vecs[i].wr) check($sformatf("vec%0d tbl_rdata", i), rd, vecs[i].exp_rdata);
      if (i == 0) begin
        check("vec0 fill addr", last_rd_addr, 16'h0000);
        check("vec0 no wb", wr_count, 0);
      end
    end
    check("wb addr", last_wr_addr, 16'h0000);
    check("wb data", last_wr_data, 64'h9023_0001_FFFF_1234);
    check("refill addr", last_rd_addr, 16'h0040);
`ifdef CACHE_STATS_EN
    check("hit_count", hit_count, 16'd3);
    check("miss_count", miss_count, 16'd2);
`endif

    // Reset during FILL_WAIT: read 0x0001 conflicts with the clean 0x0040 line.
    cpu_address = 16'h0001; cpu_read = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(mem_read && !mem_read_ack) && cyc < 40);
    check("reached fill_wait", {63'd0, mem_read && !mem_read_ack}, 64'd1);
    #1 reset_n = 1'b0;
    #1;
    check("midfill reset outputs", {cpu_ready, mem_read, mem_write, cpu_rdata, mem_address},
          {3'b000, 16'h0, 16'h0});
    check("midfill reset wdata", mem_wdata, 64'd0);
`ifdef CACHE_STATS_EN
    check("stats reset", {hit_count, miss_count}, 32'd0);
`endif
    cpu_read = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin rv[i] = 0; rdty[i] = 0; end
    @(posedge clk); #1;
    run_checked("reread 0001", 1'b0, 1'b0, 16'h0001, 16'h0, hit, rd);

    // Request dropped mid-miss: the fill still lands.
    cpu_address = 16'h0005; cpu_read = 1'b1;
    @(negedge clk);
    check("drop first lookup miss", {63'd0, cpu_ready}, 64'd0);
    @(posedge clk); #1 cpu_read = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rv[1] = 1'b1; rt[1] = '0; rdty[1] = 1'b0;
    run_checked("after drop", 1'b0, 1'b0, 16'h0005, 16'h0, hit, rd);

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      bit          wr   = 1'($urandom % 2);
      bit          both = wr && ($urandom % 4 == 0);
      logic [15:0] a    = 16'($urandom_range(0, 127));
      logic [15:0] d    = 16'($urandom);
      run_checked($sformatf("rnd%0d", n), wr, both, a, d, hit, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
